// File: rtl/disp_pkg.sv
// Shared types and constants for the display arbiter.
// Digit width, default sizes, FSM states and BCD helpers.
package disp_pkg;

  localparam int DIGIT_W     = 4;
  localparam int BIN_W_DEF   = 14;
  localparam int MAX_VAL_DEF = 9999;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic [DIGIT_W-1:0] thsnds;
    logic [DIGIT_W-1:0] hundrs;
    logic [DIGIT_W-1:0] tens;
    logic [DIGIT_W-1:0] uni;
  } digits_t;

  localparam digits_t DIG_SAT = '{
    thsnds: 4'd9,
    hundrs: 4'd9,
    tens:   4'd9,
    uni:    4'd9
  };

  function automatic logic [DIGIT_W-1:0] add3(
    input logic [DIGIT_W-1:0] d
  );
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

endpackage

// File: rtl/disp_arb_if.sv
// Request/acknowledge and display bundle of the arbiter.
// master = requester side, slave = arbiter side.
interface disp_arb_if #(
  parameter int BIN_W = disp_pkg::BIN_W_DEF
) ();
  import disp_pkg::*;

  logic               req_a;
  logic [BIN_W-1:0]   val_a;
  logic               req_b;
  logic [BIN_W-1:0]   val_b;
  logic               ack_a;
  logic               ack_b;
  logic               busy;
  logic [DIGIT_W-1:0] thsnds;
  logic [DIGIT_W-1:0] hundrs;
  logic [DIGIT_W-1:0] tens;
  logic [DIGIT_W-1:0] uni;
  logic               ovf;

  modport master (
    output req_a, val_a, req_b, val_b,
    input  ack_a, ack_b, busy,
    input  thsnds, hundrs, tens, uni, ovf
  );

  modport slave (
    input  req_a, val_a, req_b, val_b,
    output ack_a, ack_b, busy,
    output thsnds, hundrs, tens, uni, ovf
  );

endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary to BCD converter.
// One bit per cycle, MSB first; done_o marks the final shift cycle.
module bin2bcd_seq import disp_pkg::*; #(
  parameter int BIN_W = BIN_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [BIN_W-1:0] bin_i,
  output logic             done_o,
  output digits_t          bcd_o
);

  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BIN_W - 1);

  logic [BIN_W-1:0] sh_q, sh_d;
  digits_t          bcd_q, bcd_d;
  digits_t          adj;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             act_q, act_d;

  always_comb begin
    adj.thsnds = add3(bcd_q.thsnds);
    adj.hundrs = add3(bcd_q.hundrs);
    adj.tens   = add3(bcd_q.tens);
    adj.uni    = add3(bcd_q.uni);
  end

  // Carry out of the top digit is dropped; such values saturate upstream.
  always_comb begin
    sh_d  = sh_q;
    bcd_d = bcd_q;
    cnt_d = cnt_q;
    act_d = act_q;
    if (start_i) begin
      sh_d  = bin_i;
      bcd_d = '0;
      cnt_d = '0;
      act_d = 1'b1;
    end else if (act_q) begin
      bcd_d = digits_t'({adj[4*DIGIT_W-2:0], sh_q[BIN_W-1]});
      sh_d  = sh_q << 1;
      cnt_d = cnt_q + 1'b1;
      act_d = (cnt_q != LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_q  <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
      act_q <= 1'b0;
    end else begin
      sh_q  <= sh_d;
      bcd_q <= bcd_d;
      cnt_q <= cnt_d;
      act_q <= act_d;
    end
  end

  assign done_o = act_q && (cnt_q == LAST);
  assign bcd_o  = bcd_q;

endmodule

// File: rtl/disp_arb.sv
// Round-robin arbiter sharing one BCD converter between two
// display requesters, with saturation and registered digits.
module disp_arb import disp_pkg::*; #(
  parameter int BIN_W   = BIN_W_DEF,
  parameter int MAX_VAL = MAX_VAL_DEF
) (
  input logic       clk,
  input logic       rst,
  disp_arb_if.slave bus
);

  localparam logic [BIN_W-1:0] MAX_BIN = BIN_W'(MAX_VAL);

  state_e           state_q, state_d;
  logic             last_b_q, last_b_d;
  logic             sat_q, sat_d;
  logic             ovf_q, ovf_d;
  digits_t          dig_q, dig_d;
  logic             sel_b;
  logic [BIN_W-1:0] sel_val;
  logic             start;
  logic             done;
  logic             ack_a, ack_b;
  digits_t          bcd;

  // Tie goes to A unless A was the last one granted.
  assign sel_b   = bus.req_b & (~bus.req_a | ~last_b_q);
  assign sel_val = sel_b ? bus.val_b : bus.val_a;

  bin2bcd_seq #(
    .BIN_W (BIN_W)
  ) u_conv (
    .clk     (clk),
    .rst     (rst),
    .start_i (start),
    .bin_i   (sel_val),
    .done_o  (done),
    .bcd_o   (bcd)
  );

  always_comb begin
    state_d  = state_q;
    last_b_d = last_b_q;
    sat_d    = sat_q;
    ovf_d    = ovf_q;
    dig_d    = dig_q;
    start    = 1'b0;
    ack_a    = 1'b0;
    ack_b    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.req_a || bus.req_b) begin
          start    = 1'b1;
          last_b_d = sel_b;
          sat_d    = (sel_val > MAX_BIN);
          state_d  = CONV;
        end
      end
      CONV: begin
        if (done) state_d = DONE;
      end
      DONE: begin
        ack_a   = ~last_b_q;
        ack_b   = last_b_q;
        dig_d   = sat_q ? DIG_SAT : bcd;
        ovf_d   = sat_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      last_b_q <= 1'b1;
      sat_q    <= 1'b0;
      ovf_q    <= 1'b0;
      dig_q    <= '0;
    end else begin
      state_q  <= state_d;
      last_b_q <= last_b_d;
      sat_q    <= sat_d;
      ovf_q    <= ovf_d;
      dig_q    <= dig_d;
    end
  end

  assign bus.ack_a  = ack_a;
  assign bus.ack_b  = ack_b;
  assign bus.busy   = (state_q != IDLE);
  assign bus.thsnds = dig_q.thsnds;
  assign bus.hundrs = dig_q.hundrs;
  assign bus.tens   = dig_q.tens;
  assign bus.uni    = dig_q.uni;
  assign bus.ovf    = ovf_q;

endmodule

// File: tb/tb_disp_arb.sv
// Scoreboard bench for disp_arb: directed cases plus random
// requests checked against a decimal reference model.
module tb_disp_arb;
  import disp_pkg::*;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  disp_arb_if #(.BIN_W(14)) bus ();

  disp_arb #(
    .BIN_W   (14),
    .MAX_VAL (9999)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    bit          is_b;
    logic [15:0] dig;
    bit          ovf;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  bit   pend;
  bit   last_b_m;
  int   total;
  int   bad;
  int   bnd[4] = '{0, 9999, 10000, 16383};

  function automatic exp_t model(input bit is_b, input int v);
    exp_t e;
    int   d;
    e.is_b = is_b;
    e.ovf  = (v > 9999);
    d      = e.ovf ? 9999 : v;
    e.dig  = {4'(d / 1000), 4'((d / 100) % 10),
              4'((d / 10) % 10), 4'(d % 10)};
    return e;
  endfunction

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  function automatic logic [31:0] disp_now();
    return 32'({bus.thsnds, bus.hundrs, bus.tens, bus.uni});
  endfunction

  // Monitor: pops on every ack, checks digits one cycle later.
  initial begin
    pend = 1'b0;
    forever begin
      @(negedge clk);
      if (pend) begin
        pend = 1'b0;
        check("disp", disp_now(), 32'(cur.dig));
        check("ovf", 32'(bus.ovf), 32'(cur.ovf));
        check("ack_width", 32'({bus.ack_a, bus.ack_b}), 32'd0);
      end
      if (bus.ack_a || bus.ack_b) begin
        check("ack_excl", 32'(bus.ack_a & bus.ack_b), 32'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_ack", 32'({bus.ack_a, bus.ack_b}), 32'd0);
        end else begin
          cur = exp_q.pop_front();
          check("ack_who", 32'(bus.ack_b), 32'(cur.is_b));
          pend = 1'b1;
        end
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while ((bus.busy || exp_q.size() != 0 || pend) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("idle_timeout", n, 0);
  endtask

  task automatic serve(input bit ra, input bit rb,
                       input int va, input int vb,
                       input int chg_at, input int chg_val,
                       input bit drop);
    int   k;
    int   seen;
    int   want;
    exp_t ea;
    exp_t eb;
    wait_idle();
    bus.val_a = 14'(va);
    bus.val_b = 14'(vb);
    bus.req_a = ra;
    bus.req_b = rb;
    want = int'(ra) + int'(rb);
    ea = model(1'b0, va);
    eb = model(1'b1, vb);
    if (ra && rb) begin
      if (last_b_m) begin
        exp_q.push_back(ea);
        exp_q.push_back(eb);
        last_b_m = 1'b1;
      end else begin
        exp_q.push_back(eb);
        exp_q.push_back(ea);
        last_b_m = 1'b0;
      end
    end else if (ra) begin
      exp_q.push_back(ea);
      last_b_m = 1'b0;
    end else begin
      exp_q.push_back(eb);
      last_b_m = 1'b1;
    end
    k = 0;
    seen = 0;
    while (seen < want && k < 100) begin
      @(negedge clk);
      k++;
      if (want == 1 && k == chg_at) begin
        if (ra) bus.val_a = 14'(chg_val);
        else    bus.val_b = 14'(chg_val);
      end
      if (want == 1 && drop && k == 3) begin
        bus.req_a = 1'b0;
        bus.req_b = 1'b0;
      end
      if (bus.ack_a || bus.ack_b) begin
        check("ack_lat", k, (seen == 0) ? 15 : 31);
        seen++;
        if (bus.ack_a) bus.req_a = 1'b0;
        if (bus.ack_b) bus.req_b = 1'b0;
      end
    end
    if (seen < want) check("ack_timeout", seen, want);
  endtask

  function automatic int pickv();
    int sel;
    sel = int'($urandom_range(0, 3));
    if (sel == 0) return int'($urandom_range(0, 9999));
    if (sel == 1) return int'($urandom_range(10000, 16383));
    if (sel == 2) return bnd[$urandom_range(0, 3)];
    return int'($urandom_range(0, 16383));
  endfunction

  initial begin
    int mode;
    int va;
    int vb;
    total     = 0;
    bad       = 0;
    last_b_m  = 1'b1;
    rst       = 1'b1;
    bus.req_a = 1'b0;
    bus.req_b = 1'b0;
    bus.val_a = '0;
    bus.val_b = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_disp", disp_now(), 32'd0);
    check("rst_ovf", 32'(bus.ovf), 32'd0);
    check("rst_ack", 32'({bus.ack_a, bus.ack_b}), 32'd0);
    rst = 1'b0;

    serve(1, 1, 5, 42, 0, 0, 0);
    serve(1, 0, 1234, 0, 0, 0, 0);
    serve(0, 1, 0, 12000, 0, 0, 0);
    serve(0, 1, 0, 0, 0, 0, 0);
    serve(1, 0, 100, 0, 3, 200, 0);
    serve(1, 0, 0, 0, 0, 0, 0);
    serve(0, 1, 0, 9999, 0, 0, 0);
    serve(1, 0, 10000, 0, 0, 0, 0);
    serve(0, 1, 0, 16383, 0, 0, 1);
    serve(1, 1, 7, 8, 0, 0, 0);
    serve(1, 0, 31, 0, 0, 0, 0);
    serve(1, 1, 555, 666, 0, 0, 0);

    // Reset in the middle of a conversion of 8765.
    wait_idle();
    bus.val_a = 14'd8765;
    bus.req_a = 1'b1;
    @(posedge clk);
    repeat (6) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    bus.req_a = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    last_b_m = 1'b1;
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_disp", disp_now(), 32'd0);
    check("mid_rst_ovf", 32'(bus.ovf), 32'd0);
    check("mid_rst_ack", 32'({bus.ack_a, bus.ack_b}), 32'd0);
    repeat (20) @(negedge clk);
    check("post_rst_disp", disp_now(), 32'd0);
    serve(1, 1, 8765, 3, 0, 0, 0);

    for (int i = 0; i < 25; i++) begin
      mode = int'($urandom_range(0, 2));
      va   = pickv();
      vb   = pickv();
      serve(mode != 1, mode != 0, va, vb,
            int'($urandom_range(0, 14)),
            int'($urandom_range(0, 16383)),
            bit'($urandom_range(0, 1)));
    end

    wait_idle();
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
